// File: rtl/binary_image_threshold.sv
// ---------------------------------------------------------------------------
// binary_image_threshold
//   Converts RGB888 pixels to 8-bit luminance and binarises them against a
//   per-frame adaptive threshold. The threshold is the mean luminance of the
//   previous complete frame. A restoring divider computes it during the
//   following cycles while the next frame is already being accumulated.
//
//   Optional feature macro: THRESH_OVERRIDE_EN
//     When defined, the thresh_sel/thresh_manual ports are added. They
//     override the threshold used by the compare and the one shown on thresh.
//
// Ports:
//   clk            in   pixel clock
//   rst_n          in   asynchronous active-low reset
//   data_in        in   RGB pixel, R=[23:16] G=[15:8] B=[7:0]
//   data_in_en     in   pixel valid, one pixel per asserted cycle
//   thresh_sel     in   (THRESH_OVERRIDE_EN only) 1 = use thresh_manual
//   thresh_manual  in   (THRESH_OVERRIDE_EN only) manual threshold
//   data_out       out  24'h000000 or 24'hFFFFFF
//   data_out_en    out  data_out valid, 3 clocks after data_in_en
//   thresh         out  threshold currently applied
// ---------------------------------------------------------------------------
module binary_image_threshold #(
   parameter int IMG_WIDTH_DATA = 24,
   parameter int IMG_WIDTH_LINE = 640,
   parameter int IMG_HEIGHT     = 480,
   parameter int CNT_W          = 19,
   parameter int SUM_W          = 27,
   parameter int INIT_THRESH    = 128
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [IMG_WIDTH_DATA-1:0] data_in,
   input  logic                      data_in_en,
`ifdef THRESH_OVERRIDE_EN
   input  logic                      thresh_sel,
   input  logic [7:0]                thresh_manual,
`endif
   output logic [IMG_WIDTH_DATA-1:0] data_out,
   output logic                      data_out_en,
   output logic [7:0]                thresh
);

   localparam int               N        = IMG_WIDTH_LINE * IMG_HEIGHT;
   localparam int               DW       = SUM_W + 8;
   localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(N - 1);
   localparam logic [DW-1:0]    DIVISOR  = DW'(N);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DIV    = 2'd1;
   localparam logic [1:0] S_UPDATE = 2'd2;

   // Weighted sum is at most 255*256 = 65280, so it fits 16 bits; Y is the
   // truncated upper byte.
   function automatic logic [7:0] luma_trunc(input logic [15:0] s);
      return 8'(s >> 8);
   endfunction

   logic [15:0]               r_pr_p1, r_pg_p1, r_pb_p1;
   logic                      r_vld_p1;
   logic [7:0]                r_y_p2;
   logic                      r_vld_p2;
   logic [IMG_WIDTH_DATA-1:0] r_data_p3;
   logic                      r_vld_p3;

   logic [CNT_W-1:0]          r_pix_cnt;
   logic [SUM_W-1:0]          r_acc;
   logic [DW-1:0]             r_div_rem;
   logic [7:0]                r_quot;
   logic [2:0]                r_bit;
   logic [1:0]                r_state;
   logic [7:0]                r_thresh;

   logic [15:0]               w_ysum;
   logic [SUM_W-1:0]          w_acc_next;
   logic [DW-1:0]             w_dvsr;
   logic [7:0]                w_thresh_eff;

`ifdef THRESH_OVERRIDE_EN
   assign w_thresh_eff = thresh_sel ? thresh_manual : r_thresh;
`else
   assign w_thresh_eff = r_thresh;
`endif

   assign w_ysum     = r_pr_p1 + r_pg_p1 + r_pb_p1;
   assign w_acc_next = r_acc + {{(SUM_W-8){1'b0}}, r_y_p2};
   assign w_dvsr     = DIVISOR << r_bit;

   // ---- Stage 1: per-channel products ----
   always_ff @(posedge clk) begin
      r_pr_p1 <= 16'd77  * {8'd0, data_in[23:16]};
      r_pg_p1 <= 16'd150 * {8'd0, data_in[15:8]};
      r_pb_p1 <= 16'd29  * {8'd0, data_in[7:0]};
   end

   // ---- Stage 2: luminance ----
   always_ff @(posedge clk) begin
      r_y_p2 <= luma_trunc(w_ysum);
   end

   // Valid pipeline and stage 3 (binarised pixel).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_p1  <= 1'b0;
         r_vld_p2  <= 1'b0;
         r_vld_p3  <= 1'b0;
         r_data_p3 <= '0;
      end else begin
         r_vld_p1 <= data_in_en;
         r_vld_p2 <= r_vld_p1;
         // ---- Stage 3: compare; equality maps to black ----
         r_vld_p3 <= r_vld_p2;
         if (r_vld_p2)
            r_data_p3 <= (r_y_p2 > w_thresh_eff) ? '1 : '0;
      end
   end

   // Frame accounting and sequential divider. The remainder register holds
   // the finished frame sum, so r_acc is free to start the next frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pix_cnt <= '0;
         r_acc     <= '0;
         r_div_rem <= '0;
         r_quot    <= '0;
         r_bit     <= '0;
         r_state   <= S_IDLE;
         r_thresh  <= 8'(INIT_THRESH);
      end else begin
         if (r_vld_p2) begin
            if (r_pix_cnt != LAST_PIX) begin
               r_acc     <= w_acc_next;
               r_pix_cnt <= r_pix_cnt + 1'b1;
            end else begin
               r_div_rem <= DW'(w_acc_next);
               r_acc     <= '0;
               r_pix_cnt <= '0;
            end
         end

         case (r_state)
            S_IDLE: begin
               if (r_vld_p2 && (r_pix_cnt == LAST_PIX)) begin
                  r_state <= S_DIV;
                  r_bit   <= 3'd7;
                  r_quot  <= '0;
               end
            end
            S_DIV: begin
               // One restoring step per cycle, MSB of the quotient first.
               if (r_div_rem >= w_dvsr) begin
                  r_div_rem     <= r_div_rem - w_dvsr;
                  r_quot[r_bit] <= 1'b1;
               end
               if (r_bit == 3'd0)
                  r_state <= S_UPDATE;
               else
                  r_bit <= r_bit - 1'b1;
            end
            S_UPDATE: begin
               r_thresh <= r_quot;
               r_state  <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign data_out    = r_data_p3;
   assign data_out_en = r_vld_p3;
   assign thresh      = w_thresh_eff;

endmodule

// File: tb/tb_binary_image_threshold.sv
module tb_binary_image_threshold;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [23:0] data_in;
   logic        data_in_en;
   logic [23:0] data_out;
   logic        data_out_en;
   logic [7:0]  thresh;
`ifdef THRESH_OVERRIDE_EN
   logic        thresh_sel = 1'b0;
   logic [7:0]  thresh_manual = 8'd0;
`endif

   binary_image_threshold #(
      .IMG_WIDTH_DATA(24),
      .IMG_WIDTH_LINE(4),
      .IMG_HEIGHT    (4),
      .CNT_W         (19),
      .SUM_W         (27),
      .INIT_THRESH   (128)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .data_in      (data_in),
      .data_in_en   (data_in_en),
`ifdef THRESH_OVERRIDE_EN
      .thresh_sel   (thresh_sel),
      .thresh_manual(thresh_manual),
`endif
      .data_out     (data_out),
      .data_out_en  (data_out_en),
      .thresh       (thresh)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_total = 0;
   int          n_bad   = 0;
   int          n_in    = 0;
   int          n_out   = 0;
   int          last_cyc = 0;
   logic [23:0] q_exp[$];
   int          q_cyc[$];
   logic [23:0] e_pix;
   int          e_cyc;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic send(input logic [23:0] pix, input logic [23:0] exp);
      @(negedge clk);
      data_in    = pix;
      data_in_en = 1'b1;
      q_exp.push_back(exp);
      q_cyc.push_back(cyc);
      last_cyc = cyc;
      n_in++;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         data_in_en = 1'b0;
      end
   endtask

   // Output monitor: each output must match the oldest pending pixel and
   // appear exactly 3 clocks after that pixel was presented.
   always @(negedge clk) begin
      if (rst_n && data_out_en) begin
         n_out++;
         if (q_exp.size() == 0) begin
            check("spurious_out", 32'(q_exp.size()), 32'd1);
         end else begin
            e_pix = q_exp.pop_front();
            e_cyc = q_cyc.pop_front();
            check("pix", {8'd0, data_out}, {8'd0, e_pix});
            check("latency", 32'(cyc), 32'(e_cyc + 3));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n      = 1'b0;
      data_in    = '0;
      data_in_en = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_data_out", {8'd0, data_out}, 32'd0);
      check("rst_out_en",   {31'd0, data_out_en}, 32'd0);
      check("rst_thresh",   {24'd0, thresh}, 32'd128);
      rst_n = 1'b1;
      idle(2);

      // Frame 1: Y=100 everywhere, all black against 128.
      for (int i = 0; i < 16; i++) send(24'h646464, 24'h000000);
      idle(1);
      while (cyc < last_cyc + 11) idle(1);
      check("thr_before_upd", {24'd0, thresh}, 32'd128);
      idle(1);
      check("thr_after_upd", {24'd0, thresh}, 32'd100);
      idle(4);

      // Frame 2: Y=101 / Y=100 alternating against 100; mean 100.5 -> 100.
      for (int i = 0; i < 16; i++)
         if (i % 2 == 0) send(24'h656565, 24'hFFFFFF);
         else            send(24'h646464, 24'h000000);
      idle(15);
      check("thr_frame2", {24'd0, thresh}, 32'd100);

      // Frame 3: 8 white + 8 black -> 2040/16 = 127.
      for (int i = 0; i < 8; i++) send(24'hFFFFFF, 24'hFFFFFF);
      for (int i = 0; i < 8; i++) send(24'h000000, 24'h000000);
      idle(15);
      check("thr_frame3", {24'd0, thresh}, 32'd127);

      // Frame 4: Y=128 / Y=127 against 127 with random gaps.
      for (int i = 0; i < 16; i++) begin
         if (i % 2 == 0) send(24'h808080, 24'hFFFFFF);
         else            send(24'h7F7F7F, 24'h000000);
         idle($urandom_range(0, 3));
      end
      idle(15);
      check("thr_frame4", {24'd0, thresh}, 32'd127);
      check("count_io", 32'(n_out), 32'(n_in));
      check("queue_empty", 32'(q_exp.size()), 32'd0);

      // Reset after 7 pixels of a frame discards the partial frame.
      for (int i = 0; i < 7; i++) send(24'hFFFFFF, 24'hFFFFFF);
      idle(6);
      check("thr_pre_reset", {24'd0, thresh}, 32'd127);
      rst_n = 1'b0;
      idle(2);
      check("mid_rst_thresh",   {24'd0, thresh}, 32'd128);
      check("mid_rst_data_out", {8'd0, data_out}, 32'd0);
      check("mid_rst_out_en",   {31'd0, data_out_en}, 32'd0);
      rst_n = 1'b1;
      idle(1);
      for (int i = 0; i < 9; i++) send(24'h000000, 24'h000000);
      idle(14);
      check("no_early_upd", {24'd0, thresh}, 32'd128);
      for (int i = 0; i < 7; i++) send(24'h000000, 24'h000000);
      idle(14);
      check("thr_after_rst_frame", {24'd0, thresh}, 32'd0);

`ifdef THRESH_OVERRIDE_EN
      thresh_sel    = 1'b1;
      thresh_manual = 8'd200;
      idle(1);
      check("ovr_thresh", {24'd0, thresh}, 32'd200);
      send(24'hC9C9C9, 24'hFFFFFF);
      send(24'hC8C8C8, 24'h000000);
      idle(5);
      thresh_sel = 1'b0;
      idle(1);
      check("ovr_restore", {24'd0, thresh}, 32'd0);
`endif

      idle(5);
      check("final_count_io", 32'(n_out), 32'(n_in));
      check("final_queue_empty", 32'(q_exp.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
